// File: rtl/pos_edge_ff_mux_pkg.sv
// pos_edge_ff_mux_pkg: shared constants and types for the mux-built flip-flop.
// Holds DEFAULT_WIDTH, the mux select enum and a select-conversion helper.
package pos_edge_ff_mux_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // SEL_A passes the a input of a mux2, SEL_B passes the b input.
    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } mux_sel_e;

    // Turns a raw control bit (clk, rst) into a named mux select.
    function automatic mux_sel_e to_sel(input logic bit_in);
        return bit_in ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/pos_edge_ff_mux_if.sv
// pos_edge_ff_mux_if: data bundle for the mux-built flip-flop.
// Carries d (to the cell) and q (from the cell); qn is present only when
// POS_EDGE_FF_MUX_QN_EN is defined. master = driver side, slave = cell side.
interface pos_edge_ff_mux_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
`ifdef POS_EDGE_FF_MUX_QN_EN
    logic [WIDTH-1:0] qn;

    modport master (output d, input q, input qn);
    modport slave (input d, output q, output qn);
`else
    modport master (output d, input q);
    modport slave (input d, output q);
`endif
endinterface

// File: rtl/pos_edge_ff_mux_mux2.sv
// mux2: one-bit 2:1 multiplexer, the only primitive used by the flip-flop.
// Ports: a (sel=SEL_A), b (sel=SEL_B), sel, y = sel ? b : a.
module mux2
    import pos_edge_ff_mux_pkg::*;
(
    input  logic     a,
    input  logic     b,
    input  mux_sel_e sel,
    output logic     y
);

    assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/pos_edge_ff_mux.sv
// pos_edge_ff_mux: rising-edge D flip-flop built only from mux2 feedback.
// Ports: clk, rst (sync, active high), D, Q; Qn = ~Q with POS_EDGE_FF_MUX_QN_EN.
module pos_edge_ff_mux
    import pos_edge_ff_mux_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
`ifdef POS_EDGE_FF_MUX_QN_EN
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
`else
    output logic [WIDTH-1:0] Q
`endif
);

    mux_sel_e clk_sel;
    mux_sel_e rst_sel;

    assign clk_sel = to_sel(clk);
    assign rst_sel = to_sel(rst);

    logic [WIDTH-1:0] d_int;
    logic [WIDTH-1:0] m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Reset is folded into the data path ahead of the master, so it
        // can only be captured when the master closes at a rising edge.
        mux2 u_rst (
            .a   (D[i]),
            .b   (RESET_VALUE[i]),
            .sel (rst_sel),
            .y   (d_int[i])
        );

        // Master: transparent while clk is low, holds via b-feedback.
        mux2 u_master (
            .a   (d_int[i]),
            .b   (m[i]),
            .sel (clk_sel),
            .y   (m[i])
        );

        // Slave: transparent while clk is high, holds via a-feedback.
        // Master is already closed when the slave opens, giving edge action.
        mux2 u_slave (
            .a   (Q[i]),
            .b   (m[i]),
            .sel (clk_sel),
            .y   (Q[i])
        );
    end

`ifdef POS_EDGE_FF_MUX_QN_EN
    assign Qn = ~Q;
`endif

endmodule

// File: tb/tb_pos_edge_ff_mux.sv
// tb_pos_edge_ff_mux: directed bench for the mux-built flip-flop (WIDTH=4).
// Checks reset, capture, glitch rejection, falling-edge inertness, sync reset.
module tb_pos_edge_ff_mux;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pos_edge_ff_mux_if #(.WIDTH(W)) bus ();

    pos_edge_ff_mux #(
        .WIDTH       (W),
        .RESET_VALUE (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .D   (bus.d),
`ifdef POS_EDGE_FF_MUX_QN_EN
        .Q   (bus.q),
        .Qn  (bus.qn)
`else
        .Q   (bus.q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [W-1:0] obs,
                       input logic [W-1:0] exp,
                       input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input logic [W-1:0] exp, input string tag);
        chk(bus.q, exp, tag);
`ifdef POS_EDGE_FF_MUX_QN_EN
        chk(bus.qn, ~exp, {tag, "_qn"});
`endif
    endtask

    // Drive inputs 2 ns into the low phase, then check 1 ns after the edge.
    task automatic low_drive(input logic r, input logic [W-1:0] dv);
        @(negedge clk);
        #2;
        rst   = r;
        bus.d = dv;
    endtask

    task automatic edge_chk(input logic [W-1:0] exp, input string tag);
        @(posedge clk);
        #1;
        chk_q(exp, tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.d = 4'hF;

        // Reset over the first edge, then capture.
        edge_chk(4'h0, "reset");
        low_drive(1'b0, 4'hF);
        edge_chk(4'hF, "after_reset");

        // Basic capture with a pre-edge hold check each cycle.
        low_drive(1'b0, 4'h0);
        #2;
        chk_q(4'hF, "hold_pre0");
        edge_chk(4'h0, "cap0");
        low_drive(1'b0, 4'hF);
        edge_chk(4'hF, "cap1");
        low_drive(1'b0, 4'h0);
        edge_chk(4'h0, "cap2");
        low_drive(1'b0, 4'h5);
        edge_chk(4'h5, "cap3");
        low_drive(1'b0, 4'h0);
        edge_chk(4'h0, "cap4");

        // Glitch while clk is high, currently 1 ns after the edge.
        #1;
        bus.d = 4'hF;
        #2;
        bus.d = 4'h0;
        #1;
        chk_q(4'h0, "glitch_hi_now");
        edge_chk(4'h0, "glitch_hi");

        // Glitch inside the low phase that ends before the edge.
        @(negedge clk);
        #1;
        bus.d = 4'hF;
        #2;
        bus.d = 4'h0;
        edge_chk(4'h0, "glitch_lo");

        // Falling-edge inertness.
        low_drive(1'b0, 4'hF);
        edge_chk(4'hF, "fall_setup");
        #3;
        bus.d = 4'h0;
        @(negedge clk);
        #1;
        chk_q(4'hF, "fall_hold");
        edge_chk(4'h0, "fall_next");

        // Reset pulse inside the low phase is ignored.
        low_drive(1'b0, 4'hF);
        edge_chk(4'hF, "srst_setup");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_q(4'hF, "srst_low_pulse");
        edge_chk(4'hF, "srst_ignored");

        // Reset held across the edge takes effect.
        low_drive(1'b1, 4'hF);
        #2;
        chk_q(4'hF, "srst_pre_edge");
        edge_chk(4'h0, "srst_taken");

        // Multi-bit pattern.
        low_drive(1'b0, 4'hA);
        edge_chk(4'hA, "width_a");
        low_drive(1'b0, 4'h3);
        edge_chk(4'h3, "width_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
